// File: rtl/logic_unit_pkg.sv
// Op codes and the per-bit gate function shared by the logic unit pipeline.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  // One bit of any op; the top replicates it across the operand width.
  function automatic logic lu_gate_bit(input op_e op, input logic a, input logic b);
    logic y;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/lu_skid_fifo2.sv
// 2-entry result buffer, 1-cycle push-to-pop latency, 1 push + 1 pop per cycle.
// push_rdy is registered (count<2 next cycle); no combinational path from pop_rdy.
module lu_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push     = push_vld & ready_q;
  assign pop      = pop_vld & pop_rdy;
  assign pop_vld  = (count != 2'd0);
  assign pop_dat  = mem[rd_ptr];
  assign push_rdy = ready_q;

  always_comb begin
    count_nxt = count;
    if (push && !pop) count_nxt = count + 2'd1;
    else if (pop && !push) count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with chain accumulator; result 1 cycle after accept.
// in_ready registered from a 2-entry buffer; define LOGIC_UNIT_REDUCE_EN for red_and/red_or/red_xor.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_chain,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] ops_cnt
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             accept;
  op_e              op;

  assign accept = in_valid & in_ready;
  assign op     = op_e'(in_op);

  // A clear landing on a chained op must already be visible to that op.
  always_comb begin
    b_eff = in_b;
    if (in_chain) b_eff = acc_clr ? '0 : acc;
  end

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = lu_gate_bit(op, in_a[i], b_eff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt <= '0;
    end else if (out_valid && out_ready && !(&ops_cnt)) begin
      ops_cnt <= ops_cnt + 1'b1;
    end
  end

  lu_skid_fifo2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (result),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (out_y)
  );

`ifdef LOGIC_UNIT_REDUCE_EN
  assign red_and = out_valid & (&out_y);
  assign red_or  = out_valid & (|out_y);
  assign red_xor = out_valid & (^out_y);
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe at WIDTH=8, CNT_W=4.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic       in_chain;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [3:0] ops_cnt;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic       red_and;
  logic       red_or;
  logic       red_xor;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_ops [8];

  always #5 clk = ~clk;

  logic_unit_pipe #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_chain  (in_chain),
    .in_a      (in_a),
    .in_b      (in_b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .ops_cnt   (ops_cnt)
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    exp_ops = '{8'h5A, 8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'hA5};

    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_chain = 1'b0;
    in_a = 8'h00; in_b = 8'h00; acc_clr = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_ops_cnt",   {28'd0, ops_cnt},   32'd0);
    check("rst_out_y",     {24'd0, out_y},     32'h00);
    rst = 1'b0;

    // All eight ops back-to-back with a free-running sink.
    out_ready = 1'b1;
    in_a = 8'hA5; in_b = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      step();
      check($sformatf("op%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("op%0d_y", i),     {24'd0, out_y},     {24'd0, exp_ops[i]});
    end
    in_valid = 1'b0;
    step();
    check("ops_drained", {31'd0, out_valid}, 32'd0);
    check("ops_cnt_8",   {28'd0, ops_cnt},   32'd8);

    // Backpressure: third push must be refused, order kept on release.
    out_ready = 1'b0; in_op = 3'd7; in_valid = 1'b1;
    in_a = 8'h11;
    step();
    check("bp_ready_1", {31'd0, in_ready}, 32'd1);
    check("bp_y_11",    {24'd0, out_y},    32'h11);
    in_a = 8'h22;
    step();
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    in_a = 8'h33;
    step();
    check("bp_ready_held", {31'd0, in_ready}, 32'd0);
    check("bp_y_stable",   {24'd0, out_y},    32'h11);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_y_22",     {24'd0, out_y},     32'h22);
    check("bp_valid_22", {31'd0, out_valid}, 32'd1);
    step();
    check("bp_no_33", {31'd0, out_valid}, 32'd0);

    // Chain: clear coinciding with a chained XOR, then chain on the result.
    in_valid = 1'b1; in_chain = 1'b1; acc_clr = 1'b1; in_op = 3'd5;
    in_a = 8'h0F; in_b = 8'hFF;
    step();
    check("chain_0f", {24'd0, out_y}, 32'h0F);
    acc_clr = 1'b0; in_a = 8'hF0;
    step();
    check("chain_ff", {24'd0, out_y}, 32'hFF);
    in_valid = 1'b0; in_chain = 1'b0;
    step();
    check("ops_cnt_12", {28'd0, ops_cnt}, 32'd12);

    // Saturation: counter must stop at 4'hF and never wrap.
    in_valid = 1'b1; in_op = 3'd7;
    for (int j = 0; j < 20; j++) begin
      in_a = 8'(j);
      step();
      exp_cnt = (12 + j > 15) ? 15 : 12 + j;
      check($sformatf("sat_cnt_%0d", j), {28'd0, ops_cnt}, 32'(exp_cnt));
    end
    in_valid = 1'b0;
    step();
    check("sat_cnt_final", {28'd0, ops_cnt}, 32'hF);

    // Fill the buffer, then reset with it full.
    out_ready = 1'b0; in_valid = 1'b1; in_a = 8'hAA;
    step();
    in_a = 8'hBB;
    step();
    check("full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    check("rst_full_valid", {31'd0, out_valid}, 32'd0);
    check("rst_full_ready", {31'd0, in_ready},  32'd1);
    check("rst_full_y",     {24'd0, out_y},     32'h00);
    check("rst_full_cnt",   {28'd0, ops_cnt},   32'd0);
    rst = 1'b0;

    // acc must be zero after reset: chained XOR returns a unchanged.
    out_ready = 1'b1; in_valid = 1'b1; in_chain = 1'b1; in_op = 3'd5;
    in_a = 8'h5A; in_b = 8'hFF;
    step();
    check("acc_after_rst", {24'd0, out_y}, 32'h5A);
    in_valid = 1'b0; in_chain = 1'b0;
    step();

`ifdef LOGIC_UNIT_REDUCE_EN
    in_valid = 1'b1; in_op = 3'd7; in_a = 8'h99; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("red_y",   {24'd0, out_y},   32'h99);
    check("red_and", {31'd0, red_and}, 32'd0);
    check("red_or",  {31'd0, red_or},  32'd1);
    check("red_xor", {31'd0, red_xor}, 32'd0);
    out_ready = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
